// File: rtl/amp_tri_gen_pkg.sv
// Shared types and constants for the triangle amplitude generator and its DAC serializer.
// is_onehot is also used by the button amplitude register.
package amp_tri_gen_pkg;
  localparam int AMP_W    = 8;
  localparam int SAMPLE_W = 9;

  localparam logic [SAMPLE_W-1:0] DAC_OFFSET = 9'd256;
  localparam logic [AMP_W-1:0]    AMP_RESET  = 8'h80;

  typedef enum logic {SER_IDLE, SER_SHIFT} ser_state_e;
  typedef enum logic {DIR_UP, DIR_DOWN}    dir_e;

  function automatic logic is_onehot(input logic [AMP_W-1:0] m);
    return (m != '0) && ((m & (m - AMP_W'(1))) == '0);
  endfunction
endpackage

// File: rtl/amp_tri_gen_if.sv
// Sample-step/amplitude inputs plus sample and serial DAC outputs of amp_tri_gen.
interface amp_tri_gen_if;
  import amp_tri_gen_pkg::*;

  logic                       ce;
  logic [AMP_W-1:0]           M;
  logic signed [SAMPLE_W-1:0] Y;
  logic [AMP_W-1:0]           M_act;
  logic                       SCLK;
  logic                       SDAT;
  logic                       SYNC;
  logic                       OVR;

  modport master (output ce, M, input Y, M_act, SCLK, SDAT, SYNC, OVR);
  modport slave  (input ce, M, output Y, M_act, SCLK, SDAT, SYNC, OVR);
endinterface

// File: rtl/amp_tri_gen_dac_ser_tx.sv
// Serial DAC frame transmitter: one 9-bit offset-binary frame per accepted sample,
// MSB first, SYNC low for the whole frame; samples arriving mid-frame are dropped and flagged.
module dac_ser_tx
  import amp_tri_gen_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ce,
  input  logic signed [SAMPLE_W-1:0] sample,
  output logic                       sclk,
  output logic                       sdat,
  output logic                       sync,
  output logic                       ovr
);
  localparam int            CW      = 9;
  localparam logic [CW-1:0] DIV_HI  = CW'(DIV - 1);
  localparam logic [CW-1:0] DIV_END = CW'(2 * DIV - 1);

  ser_state_e          state_q, state_d;
  logic                pend_q, pend_d;
  logic [CW-1:0]       div_q, div_d;
  logic [3:0]          bit_q, bit_d;
  logic [SAMPLE_W-1:0] sh_q, sh_d, load_val;
  logic                sclk_d, sdat_d, sync_d, ovr_d;
  logic                busy;

  assign load_val = sample + DAC_OFFSET;
  // pend_q covers the load cycle, so a ce landing on it is also an overrun
  assign busy     = (state_q == SER_SHIFT) || pend_q;

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    div_d   = div_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    sclk_d  = sclk;
    sdat_d  = sdat;
    sync_d  = sync;
    ovr_d   = ce && busy;
    if (ce && !busy) pend_d = 1'b1;
    unique case (state_q)
      SER_IDLE: begin
        if (pend_q) begin
          pend_d  = 1'b0;
          sh_d    = load_val;
          sync_d  = 1'b0;
          sdat_d  = load_val[SAMPLE_W-1];
          bit_d   = '0;
          div_d   = '0;
          state_d = SER_SHIFT;
        end
      end
      SER_SHIFT: begin
        if (div_q == DIV_END) begin
          div_d  = '0;
          sclk_d = 1'b0;
          if (bit_q == 4'd8) begin
            sync_d  = 1'b1;
            sdat_d  = 1'b0;
            state_d = SER_IDLE;
          end else begin
            sh_d   = {sh_q[SAMPLE_W-2:0], 1'b0};
            sdat_d = sh_q[SAMPLE_W-2];
            bit_d  = bit_q + 4'd1;
          end
        end else begin
          div_d = div_q + CW'(1);
          if (div_q == DIV_HI) sclk_d = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SER_IDLE;
      pend_q  <= 1'b0;
      div_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      sclk    <= 1'b0;
      sdat    <= 1'b0;
      sync    <= 1'b1;
      ovr     <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      sclk    <= sclk_d;
      sdat    <= sdat_d;
      sync    <= sync_d;
      ovr     <= ovr_d;
    end
  end
endmodule

// File: rtl/amp_tri_gen.sv
// Signed triangle generator of peak M_act, one step per ce; amplitude changes are taken
// only at the rising zero crossing. Each sample is forwarded to the serial DAC transmitter.
module amp_tri_gen
  import amp_tri_gen_pkg::*;
#(
  parameter int DIV = 4
) (
  input logic          clk,
  input logic          rst,
  amp_tri_gen_if.slave bus
);
  logic signed [SAMPLE_W-1:0] y_q, y_d, amp;
  dir_e                       dir_q, dir_d;
  logic [AMP_W-1:0]           m_act_q, m_eff;

  always_comb begin
    m_eff = m_act_q;
    // the step taken on the crossing tick already uses the newly loaded amplitude
    if ((y_q == '0) && (dir_q == DIR_UP) && is_onehot(bus.M)) m_eff = bus.M;
    amp   = $signed({1'b0, m_eff});
    y_d   = y_q;
    dir_d = dir_q;
    if (dir_q == DIR_UP) begin
      y_d = y_q + 9'sd1;
      if (y_d == amp) dir_d = DIR_DOWN;
    end else begin
      y_d = y_q - 9'sd1;
      if (y_d == -amp) dir_d = DIR_UP;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q     <= '0;
      dir_q   <= DIR_UP;
      m_act_q <= AMP_RESET;
    end else if (bus.ce) begin
      y_q     <= y_d;
      dir_q   <= dir_d;
      m_act_q <= m_eff;
    end
  end

  assign bus.Y     = y_q;
  assign bus.M_act = m_act_q;

  dac_ser_tx #(.DIV(DIV)) u_ser (
    .clk    (clk),
    .rst    (rst),
    .ce     (bus.ce),
    .sample (y_q),
    .sclk   (bus.SCLK),
    .sdat   (bus.SDAT),
    .sync   (bus.SYNC),
    .ovr    (bus.OVR)
  );
endmodule

// File: tb/tb_amp_tri_gen.sv
// Bench for amp_tri_gen at DIV=4 and DIV=1 side by side: a phase/amplitude triangle model
// and a frame-slot model are compared every cycle, plus hand-computed directed checks.
module tb_amp_tri_gen;
  logic       clk, rst, ce;
  logic [7:0] m_in;

  amp_tri_gen_if b4 ();
  amp_tri_gen_if b1 ();
  assign b4.ce = ce;
  assign b4.M  = m_in;
  assign b1.ce = ce;
  assign b1.M  = m_in;

  amp_tri_gen #(.DIV(4)) dut4 (.clk(clk), .rst(rst), .bus(b4));
  amp_tri_gen #(.DIV(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0, cyc = 0;
  int mA = 128, mp = 0;
  int next_ok[2] = '{0, 0};
  bit ovr_exp[2] = '{0, 0};
  int ovr_cnt[2] = '{0, 0};
  int q0[$], q1[$], got0[$], got1[$];
  bit prev_sclk[2] = '{0, 0};
  bit prev_sync[2] = '{1, 1};
  int fbits[2] = '{0, 0};
  int nbits[2] = '{0, 0};
  int lowcnt[2] = '{0, 0};

  int seq_a[21] = '{4, 3, 2, 1, 0, -1, -2, -3, -4, -3, -2, -1, 0, 1, 2, 1, 0, -1, -2, -1, 0};
  int seq_b[4]  = '{1, 0, -1, 0};
  int frm_b[4]  = '{257, 256, 255, 256};

  // triangle sample at phase p of a period-4a wave starting at 0 and rising
  function automatic int tri_y(int p, int a);
    if (p <= a) return p;
    if (p <= 3 * a) return 2 * a - p;
    return p - 4 * a;
  endfunction

  task automatic chk(string name, int act, int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    mA = 128;
    mp = 0;
    for (int d = 0; d < 2; d++) begin
      next_ok[d] = 0;
      ovr_exp[d] = 0;
      ovr_cnt[d] = 0;
    end
    q0.delete(); q1.delete(); got0.delete(); got1.delete();
  endtask

  task automatic model_update();
    ovr_exp[0] = 0;
    ovr_exp[1] = 0;
    if (ce) begin
      if (mp == 0 && $countones(m_in) == 1) mA = int'(m_in);
      mp = (mp + 1) % (4 * mA);
      for (int d = 0; d < 2; d++) begin
        automatic int dv = (d == 0) ? 4 : 1;
        if (cyc >= next_ok[d]) begin
          if (d == 0) q0.push_back(tri_y(mp, mA) + 256);
          else        q1.push_back(tri_y(mp, mA) + 256);
          next_ok[d] = cyc + 18 * dv + 2;
        end else begin
          ovr_exp[d] = 1;
        end
      end
    end
  endtask

  task automatic frame_end(int d, string p);
    automatic int dv = (d == 0) ? 4 : 1;
    chk({p, " frame bits"}, nbits[d], 9);
    chk({p, " sync low clks"}, lowcnt[d], 18 * dv);
    if ((d == 0 ? q0.size() : q1.size()) == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s frame: got %0d, want no frame", p, fbits[d]);
    end else if (d == 0) begin
      chk({p, " frame"}, fbits[d], q0.pop_front());
    end else begin
      chk({p, " frame"}, fbits[d], q1.pop_front());
    end
    if (d == 0) got0.push_back(fbits[d]);
    else        got1.push_back(fbits[d]);
  endtask

  task automatic chk_dut(int d, int y, int ma, bit sclk, bit sdat, bit sync, bit ovr);
    automatic string p = (d == 0) ? "div4" : "div1";
    chk({p, " Y"}, y, tri_y(mp, mA));
    chk({p, " M_act"}, ma, mA);
    chk({p, " OVR"}, int'(ovr), int'(ovr_exp[d]));
    if (ovr) ovr_cnt[d]++;
    if (sync) begin
      chk({p, " idle SCLK"}, int'(sclk), 0);
      chk({p, " idle SDAT"}, int'(sdat), 0);
    end
    if (rst) begin
      chk({p, " reset SYNC"}, int'(sync), 1);
      prev_sclk[d] = 0;
      prev_sync[d] = 1;
      fbits[d] = 0; nbits[d] = 0; lowcnt[d] = 0;
      return;
    end
    if (!prev_sclk[d] && sclk) begin
      fbits[d] = fbits[d] * 2 + int'(sdat);
      nbits[d]++;
    end
    if (!sync) lowcnt[d]++;
    if (!prev_sync[d] && sync) begin
      frame_end(d, p);
      fbits[d] = 0; nbits[d] = 0; lowcnt[d] = 0;
    end
    prev_sclk[d] = sclk;
    prev_sync[d] = sync;
  endtask

  task automatic do_cycle();
    if (rst) model_reset();
    chk_dut(0, b4.Y, b4.M_act, b4.SCLK, b4.SDAT, b4.SYNC, b4.OVR);
    chk_dut(1, b1.Y, b1.M_act, b1.SCLK, b1.SDAT, b1.SYNC, b1.OVR);
    if (!rst) model_update();
    cyc++;
  endtask

  task automatic tick();
    @(negedge clk);
    do_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    repeat (n) tick();
  endtask

  // one ce, next ce (if any) comes gap clks later
  task automatic pulse(int gap);
    ce = 1'b1;
    tick();
    ce = 1'b0;
    idle(gap - 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(2);
  endtask

  initial begin
    rst = 1'b0; ce = 1'b0; m_in = 8'h80;
    #1 rst = 1'b1;
    idle(3);
    chk("reset Y", b4.Y, 0);
    chk("reset M_act", b4.M_act, 128);
    chk("reset SYNC", int'(b4.SYNC), 1);
    rst = 1'b0;
    idle(2);

    // full amplitude ramp, one frame per step
    repeat (8) pulse(80);
    chk("ramp Y", b4.Y, 8);
    chk("ramp M_act", b4.M_act, 128);
    chk("ramp div4 frames", got0.size(), 8);
    chk("ramp div1 frames", got1.size(), 8);
    for (int i = 0; i < got0.size(); i++) chk("ramp div4 frame val", got0[i], 257 + i);

    // amplitude 1 from reset
    m_in = 8'h01;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      pulse(80);
      chk("amp1 Y", b4.Y, seq_b[i]);
    end
    chk("amp1 M_act", b4.M_act, 1);
    chk("amp1 frames", got0.size(), 4);
    for (int i = 0; i < got0.size(); i++) chk("amp1 frame val", got0[i], frm_b[i]);

    // amplitude change requested mid-period only takes effect at the next rising crossing
    m_in = 8'h04;
    do_reset();
    repeat (3) pulse(4);
    chk("amp4 Y", b4.Y, 3);
    m_in = 8'h02;
    for (int i = 0; i < 21; i++) begin
      pulse(4);
      chk("amp4->2 Y", b4.Y, seq_a[i]);
      if (i == 12) chk("amp4->2 M_act hold", b4.M_act, 4);
      if (i == 13) chk("amp4->2 M_act load", b4.M_act, 2);
    end

    // invalid amplitudes at the crossing are ignored
    m_in = 8'h06;
    pulse(4);
    chk("multihot M_act", b4.M_act, 2);
    chk("multihot Y", b4.Y, 1);
    repeat (7) pulse(4);
    m_in = 8'h00;
    pulse(4);
    chk("zero M_act", b4.M_act, 2);
    chk("zero Y", b4.Y, 1);
    repeat (7) pulse(4);
    m_in = 8'h10;
    pulse(4);
    chk("amp16 M_act", b4.M_act, 16);
    idle(100);

    // overrun at ce spacing 10
    m_in = 8'h80;
    do_reset();
    repeat (6) pulse(10);
    chk("ovr Y", b1.Y, 6);
    idle(100);
    chk("ovr div1 pulses", ovr_cnt[1], 3);
    chk("ovr div1 frames", got1.size(), 3);
    if (got1.size() == 3) begin
      chk("ovr div1 frame0", got1[0], 257);
      chk("ovr div1 frame1", got1[1], 259);
      chk("ovr div1 frame2", got1[2], 261);
    end
    chk("ovr div4 pulses", ovr_cnt[0], 5);
    chk("ovr div4 frames", got0.size(), 1);

    // minimum spacing 18*DIV+2 is clean, one less overruns
    do_reset();
    pulse(74);
    pulse(74);
    pulse(73);
    pulse(80);
    idle(20);
    chk("spacing div4 pulses", ovr_cnt[0], 1);
    chk("spacing div4 frames", got0.size(), 3);
    chk("spacing div1 pulses", ovr_cnt[1], 0);
    chk("spacing div1 frames", got1.size(), 4);

    // reset in the middle of bit 4
    m_in = 8'h08;
    do_reset();
    pulse(1);
    idle(35);
    chk("midframe SYNC low", int'(b4.SYNC), 0);
    chk("midframe M_act", b4.M_act, 8);
    rst = 1'b1;
    #1;
    chk("async SYNC", int'(b4.SYNC), 1);
    chk("async SCLK", int'(b4.SCLK), 0);
    chk("async Y", b4.Y, 0);
    chk("async M_act", b4.M_act, 128);
    m_in = 8'h80;
    idle(3);
    rst = 1'b0;
    idle(2);
    pulse(80);
    chk("post-reset frames", got0.size(), 1);
    if (got0.size() == 1) chk("post-reset frame", got0[0], 257);

    idle(20);
    chk("div4 frames pending", q0.size(), 0);
    chk("div1 frames pending", q1.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not reach its end");
    $fatal(1);
  end
endmodule
